// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry add/subtract unit: WIDTH bits split into STAGES chunks,
// one chunk rippled and registered per stage, valid/ready handshakes on both sides.
module rca_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("rca_pipe_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] en;
  logic [STAGES:0]   v_in;

  // A stage may load unless it and every stage downstream of it are full
  // while the consumer stalls; walking from the output down avoids a
  // combinational chain through en itself.
  always_comb begin
    logic stall;
    stall = !out_ready;
    en    = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      stall                = stall && v[STAGES-1-i];
      en[STAGES-1-i]       = !stall;
    end
  end

  assign v_in      = {v, in_valid};
  assign in_ready  = en[0];
  assign out_valid = v[STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v <= '0;
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (en[i]) v[i] <= v_in[i];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CW;
    localparam int HI = LO + CW;

    logic [WIDTH-1:LO] a_d;
    logic [WIDTH-1:LO] b_d;
    logic              c_d;
    logic [CW:0]       sum;
    logic [HI-1:0]     s_nx;
    logic [HI-1:0]     s_q;
    logic              c_q;

    if (k == 0) begin : g_in
      assign a_d  = a;
      assign b_d  = sub ? ~b : b;
      assign c_d  = sub ? ~cin : cin;
      assign s_nx = sum[CW-1:0];
    end else begin : g_in
      assign a_d  = g_stage[k-1].g_fwd.a_q;
      assign b_d  = g_stage[k-1].g_fwd.b_q;
      assign c_d  = g_stage[k-1].c_q;
      assign s_nx = {sum[CW-1:0], g_stage[k-1].s_q};
    end

    assign sum = {1'b0, a_d[HI-1:LO]} + {1'b0, b_d[HI-1:LO]} + {{CW{1'b0}}, c_d};

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (en[k]) begin
        s_q <= s_nx;
        c_q <= sum[CW];
      end
    end

    // Only the chunks not yet added travel forward; lower sums ride in s_q.
    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:HI] a_q;
      logic [WIDTH-1:HI] b_q;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en[k]) begin
          a_q <= a_d[WIDTH-1:HI];
          b_q <= b_d[WIDTH-1:HI];
        end
      end
    end else begin : g_last
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          ovf_q <= 1'b0;
        end else if (en[k]) begin
          ovf_q <= (a_d[WIDTH-1] == b_d[WIDTH-1]) && (s_nx[WIDTH-1] != a_d[WIDTH-1]);
        end
      end
    end
  end

  assign s    = g_stage[STAGES-1].s_q;
  assign cout = g_stage[STAGES-1].c_q;
  assign ovf  = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_rca_pipe_adder.sv
// Scoreboard bench for rca_pipe_adder over three configurations (32/4, 32/1, 8/2),
// exercised one at a time against an arithmetic reference model.
module tb_rca_pipe_adder;

  localparam int NCFG = 3;
  localparam int WD [NCFG] = '{32, 32, 8};
  localparam int ST [NCFG] = '{4, 1, 2};

  logic        clk = 1'b0;
  logic        reset_n, in_valid, out_ready, cin, sub;
  logic [31:0] a, b;
  int          cfg;

  logic        iv_c [NCFG];
  logic        ir_c [NCFG];
  logic        ov_c [NCFG];
  logic        co_c [NCFG];
  logic        of_c [NCFG];
  logic [31:0] s_c  [NCFG];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int W = WD[g];
    logic [W-1:0] s_w;

    assign iv_c[g] = in_valid && (cfg == g);

    rca_pipe_adder #(.WIDTH(W), .STAGES(ST[g])) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (iv_c[g]),
      .in_ready  (ir_c[g]),
      .a         (a[W-1:0]),
      .b         (b[W-1:0]),
      .cin       (cin),
      .sub       (sub),
      .out_valid (ov_c[g]),
      .out_ready (out_ready),
      .s         (s_w),
      .cout      (co_c[g]),
      .ovf       (of_c[g])
    );

    assign s_c[g] = 32'(s_w);
  end

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s cfg%0d cyc%0d: got %0h, required %0h", name, cfg, cyc, act, req);
  endtask

  // Plain integer arithmetic: subtraction is a - b - cin, borrow-free means result >= 0.
  function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic c, input logic sb);
    exp_t   e;
    longint m, ua, ub, sa, sbs, u, r, ci;
    m   = (longint'(1) << w) - 1;
    ci  = c ? 1 : 0;
    ua  = longint'(av) & m;
    ub  = longint'(bv) & m;
    sa  = (ua > (m >> 1)) ? ua - (m + 1) : ua;
    sbs = (ub > (m >> 1)) ? ub - (m + 1) : ub;
    if (!sb) begin
      u      = ua + ub + ci;
      r      = sa + sbs + ci;
      e.cout = (u > m);
    end else begin
      u      = ua - ub - ci;
      r      = sa - sbs - ci;
      e.cout = (u >= 0);
    end
    e.s       = 32'(u & m);
    e.ovf     = (r > (m >> 1)) || (r < -((m >> 1) + 1));
    e.acc_cyc = 0;
    e.lat     = 1'b0;
    return e;
  endfunction

  task automatic step_op(input logic [31:0] av, input logic [31:0] bv, input logic c,
                         input logic sb, input logic ordy, input bit lat, output bit acc);
    exp_t e;
    @(negedge clk);
    a = av; b = bv; cin = c; sub = sb; in_valid = 1'b1; out_ready = ordy;
    #1;
    acc = ir_c[cfg];
    if (acc) begin
      e         = model(WD[cfg], av, bv, c, sb);
      e.acc_cyc = cyc;
      e.lat     = lat;
      q.push_back(e);
    end
  endtask

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic c,
                      input logic sb, input bit rnd, input bit lat);
    bit acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++)
      step_op(av, bv, c, sb, rnd ? ($urandom_range(0, 3) != 0) : 1'b1, lat, acc);
    if (!acc) check("accept_timeout", 64'(acc), 1);
  endtask

  task automatic idle(input int n, input bit rnd);
    repeat (n) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      a = $urandom; b = $urandom;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      idle(1, 1'b0);
      t++;
    end
    check("drain_empty", 64'(q.size()), 0);
    idle(2, 1'b0);
  endtask

  // Monitor: pops on every delivery and checks stall stability.
  logic        hold = 1'b0;
  logic [31:0] hs;
  logic        hc, ho;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!reset_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 64'(ov_c[cfg]), 1);
        check("hold_s", 64'(s_c[cfg]), 64'(hs));
        check("hold_cout", 64'(co_c[cfg]), 64'(hc));
        check("hold_ovf", 64'(of_c[cfg]), 64'(ho));
      end
      if (ov_c[cfg] && out_ready) begin
        if (q.size() == 0) begin
          check("expected_queue_size_at_output", 0, 1);
        end else begin
          e = q.pop_front();
          check("s", 64'(s_c[cfg]), 64'(e.s));
          check("cout", 64'(co_c[cfg]), 64'(e.cout));
          check("ovf", 64'(of_c[cfg]), 64'(e.ovf));
          if (e.lat) check("latency", 64'(cyc - e.acc_cyc), 64'(ST[cfg]));
        end
      end
      hold = ov_c[cfg] && !out_ready;
      hs   = s_c[cfg];
      hc   = co_c[cfg];
      ho   = of_c[cfg];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] msk, top;
    logic [31:0] oa [12];
    logic [31:0] ob [12];
    int          k, acc_cnt;
    bit          acc;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; cfg = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int g = 0; g < NCFG; g++) begin
      cfg = g;
      check("reset_out_valid", 64'(ov_c[g]), 0);
      check("reset_s", 64'(s_c[g]), 0);
      check("reset_cout", 64'(co_c[g]), 0);
      check("reset_ovf", 64'(of_c[g]), 0);
      check("reset_in_ready", 64'(ir_c[g]), 1);
    end

    for (int g = 0; g < NCFG; g++) begin
      cfg = g;
      msk = 32'((64'd1 << WD[g]) - 1);
      top = 32'(64'd1 << (WD[g] - 1));

      send(5, 3, 1'b0, 1'b0, 1'b0, 1'b1);
      drain();

      send(msk, 1, 1'b0, 1'b0, 1'b0, 1'b0);
      send(msk >> 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
      send(msk, msk, 1'b1, 1'b0, 1'b0, 1'b0);
      send(3, 5, 1'b0, 1'b1, 1'b0, 1'b0);
      send(top, 1, 1'b0, 1'b1, 1'b0, 1'b0);
      send(10, 4, 1'b1, 1'b1, 1'b0, 1'b0);
      send(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      drain();

      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++)
          send(i, j, 1'b0, 1'b0, 1'b0, 1'b1);
      drain();

      for (int i = 0; i < 12; i++) begin
        oa[i] = $urandom & msk;
        ob[i] = $urandom & msk;
      end
      k = 0; acc_cnt = 0;
      for (int t = 0; t < 10; t++) begin
        step_op(oa[k], ob[k], k[0], k[1], 1'b0, 1'b0, acc);
        if (acc) begin
          k++;
          acc_cnt++;
        end
      end
      check("stall_accepts", 64'(acc_cnt), 64'(ST[g]));
      check("stall_in_ready", 64'(ir_c[g]), 0);
      while (k < 12) begin
        send(oa[k], ob[k], k[0], k[1], 1'b0, 1'b0);
        k++;
      end
      drain();

      for (int i = 0; i < 6; i++)
        send($urandom & msk, $urandom & msk, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      q.delete();
      #1;
      check("post_reset_out_valid", 64'(ov_c[g]), 0);
      check("post_reset_in_ready", 64'(ir_c[g]), 1);
      idle(ST[g] + 2, 1'b0);
      send($urandom & msk, $urandom & msk, 1'b1, 1'b0, 1'b0, 1'b1);
      drain();

      for (int i = 0; i < 150; i++) begin
        idle($urandom_range(0, 2), 1'b1);
        send($urandom & msk, $urandom & msk, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b1, 1'b0);
      end
      drain();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
